// File: rtl/fetcher_icache.sv
// fetcher_icache: instruction fetch stage with a direct-mapped, one-instruction-per-line cache
// in front of the program memory read channel.
module fetcher_icache #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_ENTRIES         = 4,
  parameter int COUNT_BITS            = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNT_BITS-1:0]            hit_count,
  output logic [COUNT_BITS-1:0]            miss_count
);
  localparam int IB = $clog2(CACHE_ENTRIES);
  localparam int A = PROGRAM_MEM_ADDR_BITS;
  localparam logic [2:0] FETCH = 3'b001, DECODE = 3'b010;
  typedef enum logic [2:0] {IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010} state_t;
  state_t r_state;
  logic [A-IB-1:0] r_tag [CACHE_ENTRIES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_data [CACHE_ENTRIES];
  logic [CACHE_ENTRIES-1:0] r_valid;
  logic [IB-1:0] w_idx, w_fidx;
  logic w_hit, w_fill;
  assign w_idx = current_pc[IB-1:0];
  assign w_fidx = mem_read_address[IB-1:0];
  // A flush in the lookup cycle forces a miss so stale lines are never served.
  assign w_hit = !flush && r_valid[w_idx] && r_tag[w_idx] == current_pc[A-1:IB];
  assign w_fill = r_state == FETCHING && mem_read_ready;
  assign fetcher_state = r_state;
  always_ff @(posedge clk)
    if (!reset && w_fill) begin
      r_tag[w_fidx] <= mem_read_address[A-1:IB];
      r_data[w_fidx] <= mem_read_data;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      mem_read_valid <= 1'b0;
      mem_read_address <= '0;
      instruction <= '0;
      hit_count <= '0;
      miss_count <= '0;
      r_valid <= '0;
    end else begin
      if (flush) r_valid <= '0;
      else if (w_fill) r_valid[w_fidx] <= 1'b1;
      case (r_state)
        IDLE:
          if (core_state == FETCH) begin
            if (w_hit) begin
              instruction <= r_data[w_idx];
              hit_count <= hit_count + (~&hit_count ? COUNT_BITS'(1) : COUNT_BITS'(0));
              r_state <= FETCHED;
            end else begin
              mem_read_valid <= 1'b1;
              mem_read_address <= current_pc;
              miss_count <= miss_count + (~&miss_count ? COUNT_BITS'(1) : COUNT_BITS'(0));
              r_state <= FETCHING;
            end
          end
        FETCHING:
          if (mem_read_ready) begin
            instruction <= mem_read_data;
            mem_read_valid <= 1'b0;
            r_state <= FETCHED;
          end
        FETCHED: r_state <= core_state == DECODE ? IDLE : FETCHED;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetcher_icache.sv
// tb_fetcher_icache: directed fetch transactions; expected instructions are queued at issue
// and a negedge monitor pops them when the fetcher enters FETCHED.
module tb_fetcher_icache;
  logic clk = 0, reset = 1, flush = 0, mem_read_ready = 0;
  logic [2:0] core_state = 0;
  logic [7:0] current_pc = 0;
  logic [15:0] mem_read_data = 0;
  logic mem_read_valid, s_valid;
  logic [7:0] mem_read_address, s_addr;
  logic [2:0] fetcher_state, s_state;
  logic [15:0] instruction, hit_count, miss_count, s_instr;
  logic [3:0] s_hit, s_miss;
  int errors = 0, checks = 0, exp_h = 0, exp_m = 0;
  logic [15:0] q[$];
  logic [15:0] held;
  logic [2:0] prev_st = 0;
  localparam logic [2:0] FETCH = 3'b001, DECODE = 3'b010;
  localparam logic [2:0] S_IDLE = 3'b000, S_FETCHING = 3'b001, S_FETCHED = 3'b010;

  always #5 clk = ~clk;

  fetcher_icache dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc), .flush(flush),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state), .instruction(instruction),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter copy on the same stimulus so saturation is reachable in a short run.
  fetcher_icache #(.COUNT_BITS(4)) u_sat (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc), .flush(flush),
    .mem_read_valid(s_valid), .mem_read_address(s_addr),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(s_state), .instruction(s_instr),
    .hit_count(s_hit), .miss_count(s_miss)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_counts();
    check("hit_count", hit_count, exp_h);
    check("miss_count", miss_count, exp_m);
    check("sat_hit_count", s_hit, exp_h > 15 ? 15 : exp_h);
    check("sat_miss_count", s_miss, exp_m > 15 ? 15 : exp_m);
  endtask

  always @(negedge clk) begin
    if (fetcher_state == S_FETCHED && prev_st != S_FETCHED) begin
      if (q.size() == 0) check("unexpected_fetched", 1, 0);
      else check("instruction", instruction, q.pop_front());
      held = instruction;
    end else if (fetcher_state == S_FETCHED) check("instr_stable", instruction, held);
    prev_st = fetcher_state;
  end

  // dly = cycles mem_read_valid is high before the cycle in which ready is sampled (inclusive).
  task automatic fetch(input logic [7:0] pc, input bit hit, input int dly, input logic [15:0] d,
                       input bit fl_req, input bit fl_rdy);
    int n = 0;
    core_state = FETCH; current_pc = pc; flush = fl_req;
    q.push_back(d);
    @(posedge clk); #1;
    flush = 0; core_state = 3'b000; current_pc = ~pc;
    if (hit) begin
      exp_h++;
      check("hit_state", fetcher_state, S_FETCHED);
      check("hit_no_req", mem_read_valid, 0);
    end else begin
      exp_m++;
      check("miss_state", fetcher_state, S_FETCHING);
      for (int i = 0; i < dly; i++) begin
        if (mem_read_valid && mem_read_address == pc) n++;
        mem_read_data = ~d;
        if (i == dly - 1) begin mem_read_ready = 1; mem_read_data = d; flush = fl_rdy; end
        @(posedge clk); #1;
      end
      mem_read_ready = 0; flush = 0;
      check("valid_held", n, dly);
      check("fill_state", fetcher_state, S_FETCHED);
      check("valid_drop", mem_read_valid, 0);
    end
    repeat (2) @(posedge clk);
    #1;
    check("hold_fetched", fetcher_state, S_FETCHED);
    check("hold_no_req", mem_read_valid, 0);
    core_state = DECODE;
    @(posedge clk); #1;
    core_state = 3'b000;
    check("back_idle", fetcher_state, S_IDLE);
    check_counts();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", fetcher_state, S_IDLE);
    check("rst_valid", mem_read_valid, 0);
    check("rst_addr", mem_read_address, 0);
    check("rst_instr", instruction, 0);
    check_counts();
    reset = 0;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    fetch(8'h05, 0, 3, 16'hA1B2, 0, 0);   // cold miss
    fetch(8'h05, 1, 0, 16'hA1B2, 0, 0);   // hit
    fetch(8'h01, 0, 1, 16'h1111, 0, 0);   // conflict on index 1
    fetch(8'h05, 0, 1, 16'hA1B2, 0, 0);
    fetch(8'h01, 0, 2, 16'h1111, 0, 0);
    fetch(8'h01, 1, 0, 16'h1111, 0, 0);
    fetch(8'h02, 0, 2, 16'h2222, 0, 1);   // flush races the fill
    fetch(8'h02, 0, 1, 16'h2223, 0, 0);
    fetch(8'h02, 1, 0, 16'h2223, 0, 0);
    fetch(8'h02, 0, 1, 16'h2224, 1, 0);   // flush with the request
    mem_read_ready = 1; mem_read_data = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    mem_read_ready = 0;
    check("idle_ready_ignored", fetcher_state, S_IDLE);
    fetch(8'h02, 1, 0, 16'h2224, 0, 0);
    fetch(8'h13, 0, 1, 16'h3333, 0, 0);
    fetch(8'h10, 0, 4, 16'h1010, 0, 0);
    fetch(8'h13, 1, 0, 16'h3333, 0, 0);
    fetch(8'h10, 1, 0, 16'h1010, 0, 0);
    fetch(8'h02, 1, 0, 16'h2224, 0, 0);
    for (int i = 0; i < 20; i++) fetch(8'h13, 1, 0, 16'h3333, 0, 0);
    for (int i = 0; i < 14; i++) fetch(8'h13, 0, 1, 16'h3333, 1, 0);
    check("sat_hit_max", s_hit, 4'hF);
    check("sat_miss_max", s_miss, 4'hF);
    core_state = FETCH; current_pc = 8'h20;
    @(posedge clk); #1;
    core_state = 3'b000;
    check("mid_miss_state", fetcher_state, S_FETCHING);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    exp_h = 0; exp_m = 0;
    check("mid_rst_state", fetcher_state, S_IDLE);
    check("mid_rst_valid", mem_read_valid, 0);
    check("mid_rst_addr", mem_read_address, 0);
    check("mid_rst_instr", instruction, 0);
    mem_read_ready = 1; mem_read_data = 16'hBEEF;
    @(posedge clk); #1;
    mem_read_ready = 0;
    check("late_ready_state", fetcher_state, S_IDLE);
    check("late_ready_instr", instruction, 0);
    check_counts();
    fetch(8'h13, 0, 1, 16'h3434, 0, 0);   // lines invalidated by reset
    fetch(8'h13, 1, 0, 16'h3434, 0, 0);
    repeat (2) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
